// File: rtl/wb_interconnect.sv
// Wishbone classic interconnect: NM masters to NS slaves with round-robin
// arbitration, mask/base decode, an internal error slave for unmapped
// addresses and a per-transfer timeout that aborts hung slave accesses.

package picorv32_pkg;

    typedef struct packed {
        logic [31:0] a_adr;
        logic [31:0] a_dat;
        logic [3:0]  a_sel;
        logic        a_we;
        logic        a_cyc;
        logic        a_stb;
    } wb_h2d_t;

    typedef struct packed {
        logic [31:0] d_dat;
        logic        d_ack;
    } wb_d2h_t;

endpackage

module wb_interconnect
    import picorv32_pkg::*;
#(
    parameter int              NM       = 2,
    parameter int              NS       = 7,
    parameter logic [NS*32-1:0] SLV_BASE = '0,
    parameter logic [NS*32-1:0] SLV_MASK = '0,
    parameter int              TIMEOUT  = 255,
    parameter logic [31:0]     ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  wb_h2d_t [NM-1:0]     wbm_i,
    output wb_d2h_t [NM-1:0]     wbm_o,
    output wb_h2d_t [NS-1:0]     wbs_o,
    input  wb_d2h_t [NS-1:0]     wbs_i,
    output logic    [NM-1:0]     grant_o,
    output logic                 err_o,
    output logic    [1:0]        err_code_o,
    output logic    [31:0]       err_addr_o
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Arbiter state
    logic          own_vld_r;
    logic [IW-1:0] own_idx_r;
    logic [IW-1:0] last_idx_r;
    logic [IW-1:0] pick_s;
    logic          any_req_s;

    // Owner request and decode
    wb_h2d_t       own_req_s;
    logic          owner_stb_s;
    logic          hit_any_s;
    logic [SW-1:0] sel_s;
    logic          sel_ack_s;
    logic [31:0]   sel_dat_s;

    // Error slave, timeout and status
    logic          dec_ack_r;
    logic          set_dec_s;
    logic          abort_r;
    logic          set_abort_s;
    logic          cnt_en_s;
    logic [TW-1:0] tcnt_r;

    // Round-robin search: first requester starting after the last owner.
    always_comb begin
        int cand;
        cand      = 0;
        pick_s    = '0;
        any_req_s = 1'b0;
        for (int k = NM; k >= 1; k--) begin
            cand      = (int'(last_idx_r) + k) % NM;
            any_req_s = any_req_s | wbm_i[cand].a_cyc;
            pick_s    = wbm_i[cand].a_cyc ? IW'(cand) : pick_s;
        end
    end

    // Ownership register: grant on any request, release when owner drops cyc.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_vld_r  <= 1'b0;
            own_idx_r  <= '0;
            last_idx_r <= IW'(NM - 1);
        end else if (!own_vld_r) begin
            if (any_req_s) begin
                own_vld_r <= 1'b1;
                own_idx_r <= pick_s;
            end
        end else if (!wbm_i[own_idx_r].a_cyc) begin
            own_vld_r  <= 1'b0;
            last_idx_r <= own_idx_r;
        end
    end

    // One-hot grant view of the ownership registers.
    always_comb begin
        grant_o = '0;
        if (own_vld_r) begin
            grant_o[own_idx_r] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

    assign own_req_s   = own_vld_r ? wbm_i[own_idx_r] : '0;
    assign owner_stb_s = own_vld_r & own_req_s.a_stb;

    // Address decode: lowest-index matching slave wins.
    always_comb begin
        hit_any_s = 1'b0;
        sel_s     = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((own_req_s.a_adr & SLV_MASK[32*s +: 32]) == SLV_BASE[32*s +: 32]) begin
                hit_any_s = 1'b1;
                sel_s     = SW'(s);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    assign sel_ack_s = wbs_i[sel_s].d_ack;
    assign sel_dat_s = wbs_i[sel_s].d_dat;

    // Slave request routing; an abort cycle forces the selected slave idle.
    always_comb begin
        wbs_o = '0;
        if (own_vld_r && hit_any_s) begin
            wbs_o[sel_s].a_adr = own_req_s.a_adr;
            wbs_o[sel_s].a_dat = own_req_s.a_dat;
            wbs_o[sel_s].a_sel = own_req_s.a_sel;
            wbs_o[sel_s].a_we  = own_req_s.a_we;
            wbs_o[sel_s].a_cyc = own_req_s.a_cyc & ~abort_r;
            wbs_o[sel_s].a_stb = own_req_s.a_stb & ~abort_r;
        end else begin
            wbs_o = '0;
        end
    end

    // Master response routing; error acks take precedence over the slave.
    always_comb begin
        wbm_o = '0;
        if (own_vld_r) begin
            if (abort_r || dec_ack_r) begin
                wbm_o[own_idx_r].d_ack = 1'b1;
                wbm_o[own_idx_r].d_dat = ERR_DATA;
            end else if (hit_any_s) begin
                wbm_o[own_idx_r].d_ack = sel_ack_s;
                wbm_o[own_idx_r].d_dat = sel_dat_s;
            end else begin
                wbm_o[own_idx_r].d_ack = 1'b0;
                wbm_o[own_idx_r].d_dat = 32'h0000_0000;
            end
        end else begin
            wbm_o = '0;
        end
    end

    assign set_dec_s = owner_stb_s & ~hit_any_s & ~dec_ack_r;
    assign cnt_en_s  = owner_stb_s & hit_any_s & ~sel_ack_s & ~abort_r;

    // Error slave: single-cycle ack one cycle after an unmapped strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_ack_r <= 1'b0;
        end else begin
            dec_ack_r <= set_dec_s;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign set_abort_s = cnt_en_s & (tcnt_r == TW'(TIMEOUT - 1));

            // Wait counter; a slave ack on the limit cycle suppresses the abort.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tcnt_r  <= '0;
                    abort_r <= 1'b0;
                end else begin
                    abort_r <= set_abort_s;
                    if (cnt_en_s && !set_abort_s) begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end else begin
                        tcnt_r <= '0;
                    end
                end
            end
        end else begin : g_no_timeout
            assign set_abort_s = 1'b0;

            // Timeout disabled: counter and abort stay idle.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tcnt_r  <= '0;
                    abort_r <= 1'b0;
                end else begin
                    tcnt_r  <= '0;
                    abort_r <= 1'b0;
                end
            end
        end
    endgenerate

    assign err_o = dec_ack_r | abort_r;

    // Error status capture, loaded together with the error ack register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_code_o <= 2'b00;
            err_addr_o <= 32'h0000_0000;
        end else if (set_dec_s) begin
            err_code_o <= 2'b01;
            err_addr_o <= own_req_s.a_adr;
        end else if (set_abort_s) begin
            err_code_o <= 2'b10;
            err_addr_o <= own_req_s.a_adr;
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: directed scenarios plus randomized
// single transfers checked against a latency/data/error reference model.

module tb_wb_interconnect;
    import picorv32_pkg::*;

    localparam int NM      = 2;
    localparam int NS      = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    // s0 uart 0x0200_xxxx, s1 spi 0x0201_xxxx, s2 sram 0x000x_xxxx,
    // s3 0x02xx_xxxx (overlaps s0/s1, loses to them by index)
    localparam logic [NS*32-1:0] SLV_BASE = {32'h0200_0000, 32'h0000_0000, 32'h0201_0000, 32'h0200_0000};
    localparam logic [NS*32-1:0] SLV_MASK = {32'hFF00_0000, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic               clk = 1'b0;
    logic               rst_i;
    wb_h2d_t [NM-1:0]   wbm_i;
    wb_d2h_t [NM-1:0]   wbm_o;
    wb_h2d_t [NS-1:0]   wbs_o;
    wb_d2h_t [NS-1:0]   wbs_i;
    logic    [NM-1:0]   grant_o;
    logic               err_o;
    logic    [1:0]      err_code_o;
    logic    [31:0]     err_addr_o;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          sdelay [NS];
    logic [31:0] sdata  [NS];
    int          scnt   [NS];
    logic [1:0]  last_code = 2'b00;
    logic [31:0] last_addr = 32'h0;

    wb_interconnect #(
        .NM(NM), .NS(NS), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .wbm_i(wbm_i), .wbm_o(wbm_o),
        .wbs_o(wbs_o), .wbs_i(wbs_i), .grant_o(grant_o), .err_o(err_o),
        .err_code_o(err_code_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    // Slave models: ack after sdelay[s] cycles of continuous strobe.
    always_ff @(posedge clk or posedge rst_i) begin
        for (int s = 0; s < NS; s++) begin
            if (rst_i) scnt[s] <= 0;
            else if (wbs_o[s].a_stb && !wbs_i[s].d_ack) scnt[s] <= scnt[s] + 1;
            else scnt[s] <= 0;
        end
    end

    always_comb begin
        wbs_i = '0;
        for (int s = 0; s < NS; s++) begin
            wbs_i[s].d_ack = wbs_o[s].a_stb && (scnt[s] == sdelay[s]);
            wbs_i[s].d_dat = sdata[s];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++) begin
            logic [31:0] b, m;
            b = SLV_BASE[32*s +: 32];
            m = SLV_MASK[32*s +: 32];
            if ((a & m) == b) return s;
        end
        return -1;
    endfunction

    // One transfer from idle; records ack latency (cycles after the grant cycle).
    task automatic xfer(input int m, input logic [31:0] adr, input logic we,
                        output int lat, output logic [31:0] dat,
                        output int errs, output int bad);
        int  esel;
        bit  abort_exp;
        esel = ref_decode(adr);
        abort_exp = (esel >= 0) && (sdelay[esel] >= TIMEOUT);
        lat = -1; dat = 32'h0; errs = 0; bad = 0;
        @(negedge clk);
        wbm_i[m].a_adr = adr;
        wbm_i[m].a_dat = $urandom;
        wbm_i[m].a_sel = 4'hF;
        wbm_i[m].a_we  = we;
        wbm_i[m].a_cyc = 1'b1;
        wbm_i[m].a_stb = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (err_o) errs++;
            if (grant_o !== NM'(1 << m)) bad++;
            if (wbm_o[1-m].d_ack !== 1'b0) bad++;
            for (int s = 0; s < NS; s++) begin
                logic es;
                es = (s == esel) && !(abort_exp && c == TIMEOUT);
                if (wbs_o[s].a_stb !== es || wbs_o[s].a_cyc !== es) bad++;
                if (es && (wbs_o[s].a_adr !== adr || wbs_o[s].a_we !== we)) bad++;
            end
            if (wbm_o[m].d_ack === 1'b1) begin
                lat = c;
                dat = wbm_o[m].d_dat;
                break;
            end
        end
        wbm_i[m] = '0;
    endtask

    // Reference model: expected latency, data and error status from the rules.
    task automatic run_check(input string tag, input int m, input logic [31:0] adr, input logic we);
        int lat, errs, bad, esel, exp_lat, exp_err;
        logic [31:0] dat, exp_dat;
        esel = ref_decode(adr);
        if (esel < 0) begin
            exp_lat = 1; exp_dat = ERR_DATA; exp_err = 1;
            last_code = 2'b01; last_addr = adr;
        end else if (sdelay[esel] < TIMEOUT) begin
            exp_lat = sdelay[esel]; exp_dat = sdata[esel]; exp_err = 0;
        end else begin
            exp_lat = TIMEOUT; exp_dat = ERR_DATA; exp_err = 1;
            last_code = 2'b10; last_addr = adr;
        end
        xfer(m, adr, we, lat, dat, errs, bad);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dat"}, dat, exp_dat);
        chk({tag, "_err_pulses"}, errs, exp_err);
        chk({tag, "_routing"}, bad, 0);
        @(negedge clk);
        chk({tag, "_err_code"}, err_code_o, last_code);
        chk({tag, "_err_addr"}, err_addr_o, last_addr);
    endtask

    initial begin
        int k, o, prev_g;
        logic [NM-1:0] g;
        logic [31:0] adr;
        int region;

        for (int s = 0; s < NS; s++) begin
            sdelay[s] = 0;
            sdata[s]  = 32'h0;
        end
        wbm_i = '0;
        rst_i = 1'b1;
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_code", err_code_o, 0);
        chk("rst_err_addr", err_addr_o, 0);
        chk("rst_wbs", wbs_o, 0);
        chk("rst_wbm", wbm_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Round robin: both masters keep requesting uart.
        sdelay[0] = 0;
        sdata[0]  = 32'h1234_5678;
        for (int m = 0; m < NM; m++) begin
            wbm_i[m].a_adr = 32'h0200_0000 + 32'(4 * m);
            wbm_i[m].a_sel = 4'hF;
            wbm_i[m].a_cyc = 1'b1;
            wbm_i[m].a_stb = 1'b1;
        end
        k = 0;
        prev_g = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            g = grant_o;
            for (int m = 0; m < NM; m++) begin
                if (!wbm_i[m].a_cyc) begin
                    wbm_i[m].a_cyc = 1'b1;
                    wbm_i[m].a_stb = 1'b1;
                end
            end
            if (g != 0 && prev_g == 0) chk("rr_owner", g, 1 << (k % 2));
            chk("rr_idle_gap", (g == 0 || prev_g == 0 || int'(g) == prev_g), 1);
            if (g != 0) begin
                o = g[1] ? 1 : 0;
                if (wbm_o[o].d_ack) begin
                    k++;
                    wbm_i[o].a_cyc = 1'b0;
                    wbm_i[o].a_stb = 1'b0;
                end
            end
            prev_g = int'(g);
        end
        chk("rr_transfers", k, 4);
        wbm_i = '0;
        @(negedge clk);
        @(negedge clk);

        // Single-master uart read, decode miss, timeout, ack on limit cycle.
        sdelay[0] = 3;  sdata[0] = 32'h0000_0055;
        run_check("uart", 0, 32'h0200_0004, 1'b0);
        run_check("miss", 0, 32'hF000_0000, 1'b0);
        sdelay[1] = 1000; sdata[1] = 32'hCAFE_0001;
        run_check("timeout", 1, 32'h0201_0010, 1'b0);
        sdelay[1] = TIMEOUT - 1;
        run_check("ack_at_limit", 0, 32'h0201_0020, 1'b1);
        sdelay[3] = 2;  sdata[3] = 32'h0303_0303;
        run_check("overlap_s3", 1, 32'h02FF_0040, 1'b0);

        // Randomized single transfers.
        for (int i = 0; i < 30; i++) begin
            for (int s = 0; s < NS; s++) begin
                sdelay[s] = $urandom_range(0, 20);
                sdata[s]  = $urandom;
            end
            region = $urandom_range(0, 4);
            case (region)
                0: adr = 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
                1: adr = 32'h0201_0000 | ($urandom & 32'h0000_FFFF);
                2: adr = $urandom & 32'h000F_FFFF;
                3: adr = 32'h02FF_0000 | ($urandom & 32'h0000_FFFF);
                default: adr = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
            endcase
            run_check("rand", $urandom_range(0, 1), adr, 1'($urandom_range(0, 1)));
        end

        // Reset while master 1 owns the bus.
        sdelay[2] = 1000;
        @(negedge clk);
        wbm_i[1].a_adr = 32'h0000_0100;
        wbm_i[1].a_cyc = 1'b1;
        wbm_i[1].a_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_owner", grant_o, 2'b10);
        chk("mid_stb", wbs_o[2].a_stb, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_grant", grant_o, 0);
        chk("mid_rst_wbs", wbs_o, 0);
        chk("mid_rst_wbm", wbm_o, 0);
        wbm_i[0].a_adr = 32'h0200_0000;
        wbm_i[0].a_cyc = 1'b1;
        wbm_i[0].a_stb = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_first_grant", grant_o, 2'b01);
        wbm_i = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
